// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with stall hold, bubble insertion, flush, HI/LO channel and multi-cycle feedback (hilo_temp_o/cnt_o back to EX)
module ex_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4,
  parameter int CNT_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [STALL_W-1:0]  stall,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] ex_hilo_temp,
  input  logic [CNT_W-1:0]    ex_cnt,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o
);
  localparam int PW = ADDR_W + 3*DATA_W + 3;
  localparam int FW = 2*DATA_W + CNT_W;
  logic [PW-1:0] pipe_d, pipe_q;
  logic [FW-1:0] fb_d, fb_q;
  logic se, sm, clr, unused_stall;
  assign se = stall[EX_IDX];
  assign sm = stall[MEM_IDX];
  assign clr = rst || flush;
  assign unused_stall = ^stall;
  always_comb begin
    pipe_d = (clr || (se && !sm)) ? '0 : sm ? pipe_q : {ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, 1'b1};
    fb_d = (clr || (!se && !sm)) ? '0 : sm ? fb_q : {ex_hilo_temp, ex_cnt};
  end
  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
    fb_q <= fb_d;
  end
  assign {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_valid} = pipe_q;
  assign {hilo_temp_o, cnt_o} = fb_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage against a rule-level reference model
module tb_ex_mem_stage;
  logic        clk = 0, rst = 1, flush = 0;
  logic [5:0]  stall = 0;
  logic [4:0]  ex_wd = 0;
  logic        ex_wreg = 0, ex_whilo = 0;
  logic [31:0] ex_wdata = 0, ex_hi = 0, ex_lo = 0;
  logic [63:0] ex_hilo_temp = 0;
  logic [1:0]  ex_cnt = 0;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, mem_valid;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
    logic [63:0] ht;
    logic [1:0]  cnt;
  } out_t;
  out_t q[$];
  out_t m = '0;
  out_t e;
  int errors = 0, checks = 0;
  ex_mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("mem_wd", 64'(mem_wd), 64'(e.wd));
      chk("mem_wreg", 64'(mem_wreg), 64'(e.wreg));
      chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
      chk("mem_whilo", 64'(mem_whilo), 64'(e.whilo));
      chk("mem_hi", 64'(mem_hi), 64'(e.hi));
      chk("mem_lo", 64'(mem_lo), 64'(e.lo));
      chk("mem_valid", 64'(mem_valid), 64'(e.valid));
      chk("hilo_temp_o", hilo_temp_o, e.ht);
      chk("cnt_o", 64'(cnt_o), 64'(e.cnt));
    end
  end
  task automatic tick();
    out_t n;
    if (rst || flush) n = '0;
    else if (stall[4]) n = m;
    else if (stall[3]) begin
      n = '0;
      n.ht = ex_hilo_temp;
      n.cnt = ex_cnt;
    end else begin
      n = '0;
      n.wd = ex_wd;
      n.wreg = ex_wreg;
      n.wdata = ex_wdata;
      n.whilo = ex_whilo;
      n.hi = ex_hi;
      n.lo = ex_lo;
      n.valid = 1'b1;
    end
    m = n;
    q.push_back(n);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rnd_ex();
    ex_wd = 5'($urandom);
    ex_wreg = 1'($urandom);
    ex_wdata = $urandom;
    ex_whilo = 1'($urandom);
    ex_hi = $urandom;
    ex_lo = $urandom;
    ex_hilo_temp = {$urandom, $urandom};
    ex_cnt = 2'($urandom);
  endtask
  initial begin
    @(negedge clk);
    rst = 1; rnd_ex(); tick();
    rnd_ex(); tick();
    rst = 0; stall = 0; flush = 0;
    ex_wd = 5; ex_wreg = 1; ex_wdata = 32'h1234_5678; tick();
    ex_whilo = 1; ex_hi = 32'hDEAD_BEEF; ex_lo = 32'h0000_0001; tick();
    stall = 6'b001111; ex_hilo_temp = 64'h0000_0001_0000_0002; ex_cnt = 1; tick();
    ex_cnt = 2; tick();
    stall = 0; tick();
    ex_wdata = 32'hAAAA_AAAA; tick();
    stall = 6'b001111; ex_cnt = 3; tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin rnd_ex(); tick(); end
    flush = 1; tick();
    flush = 0; stall = 6'b001111; ex_cnt = 1; ex_hilo_temp = 64'h55; tick();
    flush = 1; stall = 0; tick();
    flush = 0;
    for (int i = 0; i < 500; i++) begin
      rnd_ex();
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      stall = 6'($urandom);
      tick();
    end
    rst = 0; flush = 0; stall = 0; tick();
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
